snoop_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 9-bit snooping bus (state[8:7], tag[6:4], data[3:0]) between N cache controllers and main memory. It grants the bus to one requester per transaction and broadcasts the winner's message for exactly one cycle. For ReadMiss/WriteMiss it waits a fixed memory latency, captures the memory's 4-bit reply and returns it to the winner with a done pulse.

---
 rtl/snoop_bus_arbiter_if.sv | 37 +++
 rtl/snoop_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/snoop_bus_arbiter_if.sv
// snoop_bus_arbiter_if
//   Bundles the shared snooping-bus signals between the arbiter and its
//   cache-controller requesters and main memory.
//   master modport : the arbiter (drives bus, grant, done, resp_*, busy)
//   slave modport  : requesters/memory (drive req, req_msg, mem_data)
//   req        N_REQ    per-requester level request
//   req_msg    9*N_REQ  requester i's message in bits [9i+8:9i]
//   mem_data   9        memory output, read data in [3:0]
//   bus        9        broadcast message, zero outside the broadcast cycle
//   grant      N_REQ    one-hot bus owner
//   done       N_REQ    one-hot completion pulse
//   resp_data  4        captured memory read data
//   resp_valid 1        completion carries read data
//   busy       1        arbiter not idle
interface snoop_bus_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]   req;
  logic [9*N_REQ-1:0] req_msg;
  logic [8:0]         mem_data;
  logic [8:0]         bus;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   done;
  logic [3:0]         resp_data;
  logic               resp_valid;
  logic               busy;

  modport master (
    input  req, req_msg, mem_data,
    output bus, grant, done, resp_data, resp_valid, busy
  );

  modport slave (
    output req, req_msg, mem_data,
    input  bus, grant, done, resp_data, resp_valid, busy
  );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter
//   Round-robin arbiter and sequencer for the shared 9-bit snooping bus
//   (state[8:7], tag[6:4], data[3:0]). One requester wins per transaction;
//   its message is broadcast for exactly one cycle. ReadMiss/WriteMiss
//   transactions wait MEM_LAT cycles, capture mem_data[3:0] and return it
//   with the done pulse.
//   clock : rising-edge system clock
//   reset : asynchronous active-high reset
//   sb    : snoop_bus_arbiter_if master modport (see interface header)
module snoop_bus_arbiter #(
  parameter int N_REQ   = 3,
  parameter int MEM_LAT = 2
) (
  input  logic                clock,
  input  logic                reset,
  snoop_bus_arbiter_if.master sb
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0]    CNT_INIT  = 4'(MEM_LAT - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // One-hot vector with bit idx set.
  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // ReadMiss (01) and WriteMiss (10) need a memory reply.
  function automatic logic is_miss(input logic [8:0] msg);
    is_miss = (msg[8:7] == 2'b01) || (msg[8:7] == 2'b10);
  endfunction

  // Requester index k positions after base, wrapping at N_REQ.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    rr_idx = IW'((int'(base) + k) % N_REQ);
  endfunction

  state_t          state_r;
  logic [IW-1:0]   winner_r;
  logic [IW-1:0]   last_r;
  logic [8:0]      msg_r;
  logic [3:0]      cnt_r;
  logic [8:0]      bus_r;
  logic [N_REQ-1:0] grant_r;
  logic [N_REQ-1:0] done_r;
  logic [3:0]      resp_data_r;
  logic            resp_valid_r;
  logic            busy_r;

  logic            pick_found_s;
  logic [IW-1:0]   pick_idx_s;
  logic [8:0]      msg_arr_s [N_REQ];
  logic [8:0]      msg_sel_s;
  logic            mem_hi_unused_s;

  // Only the low nibble of the memory word carries read data.
  assign mem_hi_unused_s = ^sb.mem_data[8:4];

  // Split the flat message vector into one 9-bit word per requester.
  for (genvar g = 0; g < N_REQ; g++) begin : g_msg
    assign msg_arr_s[g] = sb.req_msg[9*g+8 -: 9];
  end

  // Round-robin pick: scanning from the farthest candidate back to last+1
  // lets the closest requesting index overwrite and win.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = {IW{1'b0}};
    for (int k = N_REQ; k >= 1; k--) begin
      if (sb.req[rr_idx(last_r, k)]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = rr_idx(last_r, k);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Message of the selected requester.
  always_comb begin
    msg_sel_s = msg_arr_s[pick_idx_s];
  end

  // Transaction FSM; every output is registered with its next-state value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      winner_r     <= {IW{1'b0}};
      last_r       <= LAST_INIT;
      msg_r        <= 9'h000;
      cnt_r        <= 4'd0;
      bus_r        <= 9'h000;
      grant_r      <= {N_REQ{1'b0}};
      done_r       <= {N_REQ{1'b0}};
      resp_data_r  <= 4'h0;
      resp_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            winner_r <= pick_idx_s;
            msg_r    <= msg_sel_s;
            bus_r    <= msg_sel_s;
            grant_r  <= onehot(pick_idx_s);
            busy_r   <= 1'b1;
            state_r  <= ST_BUS;
          end else begin
            bus_r    <= 9'h000;
            grant_r  <= {N_REQ{1'b0}};
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end
          done_r       <= {N_REQ{1'b0}};
          resp_valid_r <= 1'b0;
        end
        ST_BUS: begin
          bus_r <= 9'h000;
          if (is_miss(msg_r)) begin
            cnt_r   <= CNT_INIT;
            state_r <= ST_WAIT;
          end else begin
            done_r       <= onehot(winner_r);
            resp_valid_r <= 1'b0;
            state_r      <= ST_DONE;
          end
        end
        ST_WAIT: begin
          // Counter reaching zero marks the cycle whose end holds valid memory data.
          if (cnt_r == 4'd0) begin
            resp_data_r  <= sb.mem_data[3:0];
            resp_valid_r <= 1'b1;
            done_r       <= onehot(winner_r);
            state_r      <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_DONE: begin
          last_r       <= winner_r;
          grant_r      <= {N_REQ{1'b0}};
          done_r       <= {N_REQ{1'b0}};
          resp_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          bus_r        <= 9'h000;
          grant_r      <= {N_REQ{1'b0}};
          done_r       <= {N_REQ{1'b0}};
          resp_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign sb.bus        = bus_r;
  assign sb.grant      = grant_r;
  assign sb.done       = done_r;
  assign sb.resp_data  = resp_data_r;
  assign sb.resp_valid = resp_valid_r;
  assign sb.busy       = busy_r;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter
//   Directed stimulus for snoop_bus_arbiter with a transaction-timeline model
//   that predicts every output on every cycle, plus literal expectations for
//   the individual scenarios.
module tb_snoop_bus_arbiter;
  localparam int N       = 3;
  localparam int MEM_LAT = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  snoop_bus_arbiter_if #(.N_REQ(N)) sb();

  snoop_bus_arbiter #(.N_REQ(N), .MEM_LAT(MEM_LAT)) dut (
    .clock (clock),
    .reset (reset),
    .sb    (sb)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    oh_idx = -1;
    for (int i = 0; i < N; i++) begin
      if (v[i]) oh_idx = i;
    end
  endfunction

  // ---------------- timeline model ----------------
  // A transaction is (start cycle s, end cycle e, winner w, message).
  // Bus shows the message at s, grant covers s..e, done/resp at e.
  int         cyc = 0;
  bit         m_act = 1'b0;
  bit         m_miss = 1'b0;
  int         m_s = 0, m_e = 0, m_w = 0, m_last = N - 1;
  logic [8:0] m_msg = 9'h000;
  logic [3:0] m_rd = 4'h0;

  initial begin
    bit           found;
    int           idx;
    bit           in_tx;
    logic [8:0]   e_bus;
    logic [N-1:0] e_grant, e_done;
    bit           e_rv;
    forever begin
      @(posedge clock);
      cyc++;
      if (reset) begin
        m_act  = 1'b0;
        m_last = N - 1;
        m_rd   = 4'h0;
      end else begin
        if (m_act && cyc == m_e && m_miss) m_rd = sb.mem_data[3:0];
        if (!m_act || (cyc - 1 > m_e)) begin
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (!found && sb.req[idx]) begin
              found = 1'b1;
              m_w   = idx;
            end
          end
          if (found) begin
            m_act  = 1'b1;
            m_s    = cyc;
            m_msg  = sb.req_msg[9*m_w +: 9];
            m_miss = (m_msg[8:7] == 2'b01) || (m_msg[8:7] == 2'b10);
            m_e    = m_miss ? cyc + 1 + MEM_LAT : cyc + 1;
            m_last = m_w;
          end
        end
      end
      @(negedge clock);
      in_tx   = m_act && (cyc >= m_s) && (cyc <= m_e);
      e_bus   = (in_tx && cyc == m_s) ? m_msg : 9'h000;
      e_grant = in_tx ? (N'(1) << m_w) : {N{1'b0}};
      e_done  = (in_tx && cyc == m_e) ? (N'(1) << m_w) : {N{1'b0}};
      e_rv    = in_tx && (cyc == m_e) && m_miss;
      chk("model_bus", 32'(sb.bus), 32'(e_bus));
      chk("model_grant", 32'(sb.grant), 32'(e_grant));
      chk("model_done", 32'(sb.done), 32'(e_done));
      chk("model_resp_valid", 32'(sb.resp_valid), 32'(e_rv));
      chk("model_busy", 32'(sb.busy), 32'(in_tx));
      if (e_rv) chk("model_resp_data", 32'(sb.resp_data), 32'(m_rd));
    end
  end

  // ---------------- stimulus helpers ----------------
  int got_w[$];
  int got_c[$];
  int dn_rv[$];
  int dn_rd[$];

  task automatic tick();
    @(negedge clock);
  endtask

  // Runs ncyc cycles acting as well-behaved requesters: each drops its req on done.
  task automatic collect(input int ncyc);
    got_w.delete();
    got_c.delete();
    dn_rv.delete();
    dn_rd.delete();
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (sb.bus != 9'h000) begin
        got_w.push_back(oh_idx(sb.grant));
        got_c.push_back(cyc);
      end
      if (sb.done != {N{1'b0}}) begin
        dn_rv.push_back(int'(sb.resp_valid));
        dn_rd.push_back(int'(sb.resp_data));
      end
      sb.req = sb.req & ~sb.done;
    end
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    sb.req      = {N{1'b0}};
    sb.req_msg  = {(9*N){1'b0}};
    sb.mem_data = 9'h000;
    #1 reset = 1'b1;
    tick();
    tick();
    // Reset values
    chk("rst_bus", 32'(sb.bus), 32'h0);
    chk("rst_grant", 32'(sb.grant), 32'h0);
    chk("rst_done", 32'(sb.done), 32'h0);
    chk("rst_resp_data", 32'(sb.resp_data), 32'h0);
    chk("rst_resp_valid", 32'(sb.resp_valid), 32'h0);
    chk("rst_busy", 32'(sb.busy), 32'h0);
    reset = 1'b0;

    // Single WriteBack from requester 1
    tick();
    sb.req_msg = {9'h000, 9'h1E5, 9'h000};
    sb.req     = 3'b010;
    tick();
    chk("t1_bus", 32'(sb.bus), 32'h1E5);
    chk("t1_grant", 32'(sb.grant), 32'h2);
    chk("t1_done_early", 32'(sb.done), 32'h0);
    tick();
    chk("t1_bus_once", 32'(sb.bus), 32'h0);
    chk("t1_done", 32'(sb.done), 32'h2);
    chk("t1_resp_valid", 32'(sb.resp_valid), 32'h0);
    sb.req = 3'b000;
    tick();
    chk("t1_idle_busy", 32'(sb.busy), 32'h0);

    // Single ReadMiss from requester 0, memory answers 4'hA at the right time
    sb.req_msg  = {9'h000, 9'h000, 9'h0B0};
    sb.mem_data = 9'h005;
    sb.req      = 3'b001;
    tick();
    chk("t2_bus", 32'(sb.bus), 32'h0B0);
    chk("t2_grant", 32'(sb.grant), 32'h1);
    tick();
    chk("t2_wait1_bus", 32'(sb.bus), 32'h0);
    chk("t2_wait1_done", 32'(sb.done), 32'h0);
    chk("t2_wait1_busy", 32'(sb.busy), 32'h1);
    tick();
    chk("t2_wait2_done", 32'(sb.done), 32'h0);
    sb.mem_data = 9'h00A;
    tick();
    sb.mem_data = 9'h005;
    chk("t2_done", 32'(sb.done), 32'h1);
    chk("t2_resp_valid", 32'(sb.resp_valid), 32'h1);
    chk("t2_resp_data", 32'(sb.resp_data), 32'hA);
    chk("t2_grant_held", 32'(sb.grant), 32'h1);
    sb.req = 3'b000;
    tick();
    chk("t2_idle_rv", 32'(sb.resp_valid), 32'h0);

    // All three WriteBacks from reset: order 0,1,2 with 3-cycle bus spacing
    do_reset();
    sb.req_msg = {9'h1C3, 9'h1A2, 9'h191};
    sb.req     = 3'b111;
    collect(12);
    chk("t3_count", 32'(got_w.size()), 32'd3);
    chk("t3_w0", 32'(got_w.size() > 0 ? got_w[0] : -1), 32'd0);
    chk("t3_w1", 32'(got_w.size() > 1 ? got_w[1] : -1), 32'd1);
    chk("t3_w2", 32'(got_w.size() > 2 ? got_w[2] : -1), 32'd2);
    chk("t3_gap01", 32'(got_c.size() > 1 ? got_c[1] - got_c[0] : -1), 32'd3);
    chk("t3_gap12", 32'(got_c.size() > 2 ? got_c[2] - got_c[1] : -1), 32'd3);

    // Fairness: after serving 1, simultaneous 0 and 2 -> 2 first, then 0
    sb.req = 3'b010;
    collect(5);
    chk("t4_first_w", 32'(got_w.size() > 0 ? got_w[0] : -1), 32'd1);
    sb.req = 3'b101;
    collect(10);
    chk("t4_count", 32'(got_w.size()), 32'd2);
    chk("t4_w0", 32'(got_w.size() > 0 ? got_w[0] : -1), 32'd2);
    chk("t4_w1", 32'(got_w.size() > 1 ? got_w[1] : -1), 32'd0);

    // Reset during WAIT aborts the ReadMiss; afterwards 0 wins over 2
    sb.req_msg  = {9'h1C3, 9'h000, 9'h0B0};
    sb.mem_data = 9'h00C;
    sb.req      = 3'b001;
    tick();
    chk("t5_bus", 32'(sb.bus), 32'h0B0);
    tick();
    chk("t5_in_wait", 32'(sb.busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_bus", 32'(sb.bus), 32'h0);
    chk("t5_async_grant", 32'(sb.grant), 32'h0);
    chk("t5_async_done", 32'(sb.done), 32'h0);
    chk("t5_async_busy", 32'(sb.busy), 32'h0);
    sb.req = 3'b101;
    tick();
    chk("t5_no_done", 32'(sb.done), 32'h0);
    reset = 1'b0;
    collect(12);
    chk("t5_count", 32'(got_w.size()), 32'd2);
    chk("t5_w0", 32'(got_w.size() > 0 ? got_w[0] : -1), 32'd0);
    chk("t5_w1", 32'(got_w.size() > 1 ? got_w[1] : -1), 32'd2);
    chk("t5_rv0", 32'(dn_rv.size() > 0 ? dn_rv[0] : -1), 32'd1);
    chk("t5_rd0", 32'(dn_rd.size() > 0 ? dn_rd[0] : -1), 32'hC);
    chk("t5_rv1", 32'(dn_rv.size() > 1 ? dn_rv[1] : -1), 32'd0);

    // Null message from requester 2 completes without a WAIT phase
    sb.req_msg = {9'h000, 9'h000, 9'h000};
    sb.req     = 3'b100;
    tick();
    chk("t6_grant", 32'(sb.grant), 32'h4);
    chk("t6_bus", 32'(sb.bus), 32'h0);
    chk("t6_busy", 32'(sb.busy), 32'h1);
    tick();
    chk("t6_done", 32'(sb.done), 32'h4);
    chk("t6_resp_valid", 32'(sb.resp_valid), 32'h0);
    sb.req = 3'b000;
    tick();
    chk("t6_idle_busy", 32'(sb.busy), 32'h0);
    chk("t6_idle_done", 32'(sb.done), 32'h0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
